mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared-memory arbiter between the per-CPU instruction and data caches and the single RAM port. It collects every cache's miss and writeback requests, grants one at a time, and latches the winner's access onto the RAM port. It holds that access until RAM reports completion, then releases the winner's wait line. Data traffic takes priority over instruction traffic, and CPUs are served round-robin within each class.

## Interface
- CPUS, 2, number of CPUs; each CPU has one icache and one dcache requester
- AW, 32, address width
- DW, 32, data width
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  CPUS  icache read request, one bit per CPU
- iaddr  in  CPUS×AW  icache word address
- dREN  in  CPUS  dcache read request
- dWEN  in  CPUS  dcache write request
- daddr  in  CPUS×AW  dcache address
- dstore  in  CPUS×DW  dcache write data
- iwait  out  CPUS  1 = icache access not completing this cycle
- dwait  out  CPUS  1 = dcache access not completing this cycle
- iload  out  CPUS×DW  read data to each icache (ramload broadcast)
- dload  out  CPUS×DW  read data to each dcache (ramload broadcast)
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  AW  RAM address
- ramstore  out  DW  RAM write data
- ramload  in  DW  RAM read data; valid in the ram_rdy cycle
- ram_rdy  in  1  one-cycle pulse; the current RAM access completes this cycle

## Operation
- States:
  - IDLE: no access outstanding; ramREN = ramWEN = 0.
  - BUSY: the latched access is on the RAM port.
- Requesters, 2×CPUS in total:
  - D[c] is active when dREN[c] | dWEN[c].
  - I[c] is active when iREN[c].
- Arbitration runs in IDLE only:
  - Any active D request beats every I request.
  - Within a class, round-robin: search starts at CPU (last_granted_class + 1) mod CPUS.
  - Separate pointers dptr and iptr; the granted class's pointer updates to the winner's CPU index at grant.
- Grant (IDLE with any request active, at the clock edge):
  - Latch winner id: class and CPU.
  - Latch ramaddr ← daddr[c] or iaddr[c].
  - Latch ramstore ← dstore[c]; don't-care for I.
  - Latch type: a D request with dWEN[c]=1 is a write, including when dREN[c] is also 1. All others are reads.
  - Go to BUSY.
- BUSY:
  - ramREN/ramWEN reflect the latched type.
  - ramaddr/ramstore are held constant from the latches.
  - Requester inputs are ignored; a request dropped mid-access still completes.
- Completion: in BUSY with ram_rdy=1:
  - The winner's wait bit is 0 for that cycle only.
  - iload/dload carry ramload.
  - Next state is IDLE.
- Wait lines: every iwait/dwait bit not completing this cycle is 1, including requesters that are idle.
- ram_rdy in IDLE is ignored; no wait bit drops.
- Reset:
  - On any edge with RST=1: state ← IDLE, dptr ← CPUS-1, iptr ← CPUS-1 (so CPU0 wins first), latches ← 0.
  - An in-flight access is abandoned.
  - While in IDLE after reset, all wait bits are 1 and RAM strobes are 0.

## Timing
- Request seen in cycle N (state IDLE) → RAM strobe asserted from cycle N+1.
- RAM access completes in cycle N+L (L ≥ 1): ram_rdy=1 and the winner's wait=0 in that cycle.
- IDLE again in cycle N+L+1, when the next grant is decided.
- Minimum spacing is one IDLE cycle between consecutive accesses. Best-case throughput is one access per 2 cycles when ram_rdy arrives in the first BUSY cycle.
- Outputs:
  - ramREN, ramWEN, ramaddr, ramstore come straight from registers.
  - iwait/dwait combine registered winner state with ram_rdy.
  - iload/dload are pure wires from ramload.
- Starvation bound: with constant D traffic, I requests wait indefinitely. This is accepted by design; caches never issue continuous D traffic.

## Test plan
- Reset:
  - Stimulus: hold RST for 2 cycles with dREN[0]=1.
  - Required: ramREN=0 and all wait bits = 1 during reset.
  - Required: the first grant goes to D0 at the first edge after release.
- Single read:
  - Stimulus: iREN[1]=1, iaddr[1]=0x40; ram_rdy pulses 3 cycles after grant with ramload=0xDEADBEEF.
  - Required: ramREN=1 and ramaddr=0x40 held for 3 cycles.
  - Required: iwait[1]=0 and iload[1]=0xDEADBEEF only in the ram_rdy cycle.
- Priority:
  - Stimulus: iREN[0], dREN[1], dWEN[0] all raised together; each access gets ram_rdy the cycle after grant.
  - Required order: D0 write, then D1 read, then I0.
  - Required: ramWEN=1 with ramstore=dstore[0] for the first access.
- Round-robin:
  - Stimulus: dREN[0] and dREN[1] held high continuously.
  - Required: grants alternate 0,1,0,1.
  - Required: dwait bits drop on alternating completions.
- Request drop and reset mid-access:
  - Stimulus: dWEN[1] deasserted while BUSY.
  - Required: the RAM write stays asserted until ram_rdy and dwait[1] still pulses 0.
  - Stimulus: separately, RST asserted while BUSY.
  - Required: the next cycle is IDLE with strobes 0, and a late ram_rdy causes no wait drop.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared RAM port arbiter for per-CPU icache/dcache requesters
// Data requests beat instruction requests; round-robin across CPUs within each class.
module mem_arbiter #(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*AW-1:0]   iaddr,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*AW-1:0]   daddr,
  input  logic [CPUS*DW-1:0]   dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*DW-1:0]   iload,
  output logic [CPUS*DW-1:0]   dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [AW-1:0]        ramaddr,
  output logic [DW-1:0]        ramstore,
  input  logic [DW-1:0]        ramload,
  input  logic                 ram_rdy
);
  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_dptr, r_iptr, r_win_cpu;
  logic            r_win_d, r_ren, r_wen;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_store;

  logic [CPUS-1:0] w_dact;
  logic            w_d_any, w_i_any, w_grant, w_done;
  logic [PW-1:0]   w_d_cpu, w_i_cpu;

  assign w_dact  = dREN | dWEN;
  assign w_d_any = |w_dact;
  assign w_i_any = |iREN;
  assign w_grant = (r_state == IDLE) && (w_d_any || w_i_any);
  assign w_done  = (r_state == BUSY) && ram_rdy;

  // Scan from farthest to nearest so the CPU closest after the pointer is assigned last.
  always_comb begin
    int di;
    int ii;
    w_d_cpu = r_dptr;
    w_i_cpu = r_iptr;
    di = 0;
    ii = 0;
    for (int k = CPUS; k >= 1; k--) begin
      di = (int'(r_dptr) + k) % CPUS;
      ii = (int'(r_iptr) + k) % CPUS;
      if (w_dact[di]) w_d_cpu = PW'(di);
      if (iREN[ii])   w_i_cpu = PW'(ii);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = BUSY;
      BUSY:    if (ram_rdy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dptr    <= PW'(CPUS - 1);
      r_iptr    <= PW'(CPUS - 1);
      r_win_cpu <= '0;
      r_win_d   <= 1'b0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_store   <= '0;
    end else if (w_grant) begin
      r_win_d <= w_d_any;
      if (w_d_any) begin
        r_win_cpu <= w_d_cpu;
        r_dptr    <= w_d_cpu;
        r_addr    <= daddr[w_d_cpu*AW +: AW];
        r_store   <= dstore[w_d_cpu*DW +: DW];
        r_wen     <= dWEN[w_d_cpu];
        r_ren     <= ~dWEN[w_d_cpu];
      end else begin
        r_win_cpu <= w_i_cpu;
        r_iptr    <= w_i_cpu;
        r_addr    <= iaddr[w_i_cpu*AW +: AW];
        r_wen     <= 1'b0;
        r_ren     <= 1'b1;
      end
    end else if (w_done) begin
      r_ren <= 1'b0;
      r_wen <= 1'b0;
    end
  end

  always_comb begin
    iwait = '1;
    dwait = '1;
    if (w_done) begin
      if (r_win_d) dwait[r_win_cpu] = 1'b0;
      else         iwait[r_win_cpu] = 1'b0;
    end
  end

  assign ramREN   = r_ren;
  assign ramWEN   = r_wen;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign iload    = {CPUS{ramload}};
  assign dload    = {CPUS{ramload}};
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        CLK, RST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait;
  logic [63:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ram_rdy;

  int n_assert = 0;
  int n_fail   = 0;
  int m_dptr   = 1;
  int m_iptr   = 1;

  mem_arbiter #(.CPUS(2), .AW(32), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_rdy(ram_rdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_chk(input string tag, input bit late_rdy);
    ram_rdy = late_rdy;
    #1;
    chk({tag, " ramREN"}, {63'd0, ramREN}, 64'd0);
    chk({tag, " ramWEN"}, {63'd0, ramWEN}, 64'd0);
    chk({tag, " iwait"},  {62'd0, iwait},  64'd3);
    chk({tag, " dwait"},  {62'd0, dwait},  64'd3);
    ram_rdy = 1'b0;
  endtask

  // Called just after the grant edge; ram_rdy is raised in the L-th BUSY cycle.
  task automatic run_access(input int L, input bit is_d, input int cpu, input bit wr,
                            input logic [31:0] addr, input logic [31:0] store,
                            input logic [31:0] load_val, input string tag);
    logic [1:0] exp_i, exp_d;
    for (int k = 1; k <= L; k++) begin
      ram_rdy = (k == L);
      ramload = (k == L) ? load_val : $urandom;
      #1;
      exp_i = 2'b11;
      exp_d = 2'b11;
      if (k == L) begin
        if (is_d) exp_d[cpu] = 1'b0;
        else      exp_i[cpu] = 1'b0;
      end
      chk($sformatf("%s c%0d ramREN", tag, k), {63'd0, ramREN}, {63'd0, !wr});
      chk($sformatf("%s c%0d ramWEN", tag, k), {63'd0, ramWEN}, {63'd0, wr});
      chk($sformatf("%s c%0d ramaddr", tag, k), {32'd0, ramaddr}, {32'd0, addr});
      if (is_d) chk($sformatf("%s c%0d ramstore", tag, k), {32'd0, ramstore}, {32'd0, store});
      chk($sformatf("%s c%0d iwait", tag, k), {62'd0, iwait}, {62'd0, exp_i});
      chk($sformatf("%s c%0d dwait", tag, k), {62'd0, dwait}, {62'd0, exp_d});
      if (k == L) begin
        chk($sformatf("%s iload", tag), iload, {load_val, load_val});
        chk($sformatf("%s dload", tag), dload, {load_val, load_val});
      end
      tick();
    end
    ram_rdy = 1'b0;
  endtask

  // Reference arbitration: D class first, then nearest CPU after that class's last winner.
  task automatic pick(output bit found, output bit is_d, output int cpu, output bit wr);
    logic [1:0] da;
    int c;
    da = dREN | dWEN;
    found = 1'b0; is_d = 1'b0; cpu = 0; wr = 1'b0;
    if (da != 2'b00) begin
      for (int k = 1; k <= 2; k++) begin
        c = (m_dptr + k) % 2;
        if (!found && da[c]) begin found = 1'b1; cpu = c; end
      end
      is_d = 1'b1;
      wr = dWEN[cpu];
      m_dptr = cpu;
    end else if (iREN != 2'b00) begin
      for (int k = 1; k <= 2; k++) begin
        c = (m_iptr + k) % 2;
        if (!found && iREN[c]) begin found = 1'b1; cpu = c; end
      end
      m_iptr = cpu;
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, is_d, wr;
    int cpu;
    logic [31:0] a, s;

    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ram_rdy = 0;

    // Reset held two cycles with D0 requesting; first grant after release goes to D0.
    RST = 1'b1;
    dREN = 2'b01;
    daddr = {32'h0000_0200, 32'h0000_0100};
    dstore = {32'h2222_2222, 32'h1111_1111};
    tick(); idle_chk("rst1", 1'b0);
    tick(); idle_chk("rst2", 1'b0);
    RST = 1'b0;
    tick();
    dREN = 2'b00;
    run_access(1, 1'b1, 0, 1'b0, 32'h100, 32'h1111_1111, $urandom, "rst_d0");

    // Single icache read on CPU1, completion three cycles after grant.
    iREN = 2'b10;
    iaddr = {32'h0000_0040, 32'h0000_0999};
    idle_chk("rd_idle", 1'b0);
    tick();
    iREN = 2'b00;
    run_access(3, 1'b0, 1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, "rd_i1");

    // Priority: D0 write, D1 read, I0 from a fresh reset.
    RST = 1'b1; tick(); RST = 1'b0;
    iREN = 2'b01; dREN = 2'b10; dWEN = 2'b01;
    iaddr = {32'h0000_0AAA, 32'h0000_0A00};
    daddr = {32'h0000_0D10, 32'h0000_0D00};
    dstore = {32'hCAFE_0001, 32'hCAFE_0000};
    idle_chk("pri_idle", 1'b0);
    tick();
    run_access(1, 1'b1, 0, 1'b1, 32'hD00, 32'hCAFE_0000, $urandom, "pri_d0w");
    dWEN = 2'b00;
    idle_chk("pri_idle2", 1'b0);
    tick();
    run_access(1, 1'b1, 1, 1'b0, 32'hD10, 32'hCAFE_0001, $urandom, "pri_d1r");
    dREN = 2'b00;
    idle_chk("pri_idle3", 1'b0);
    tick();
    iREN = 2'b00;
    run_access(1, 1'b0, 0, 1'b0, 32'hA00, 32'h0, $urandom, "pri_i0");

    // Round-robin between two continuous D readers.
    dREN = 2'b11;
    for (int g = 0; g < 4; g++) begin
      idle_chk($sformatf("rr_idle%0d", g), 1'b0);
      tick();
      run_access(1 + (g % 2), 1'b1, g % 2, 1'b0,
                 (g % 2) ? 32'hD10 : 32'hD00, (g % 2) ? 32'hCAFE_0001 : 32'hCAFE_0000,
                 $urandom, $sformatf("rr%0d", g));
    end
    dREN = 2'b00;

    // Write request dropped mid-access still completes.
    dWEN = 2'b10;
    daddr[63:32] = 32'h0000_0F00;
    dstore[63:32] = 32'h5A5A_A5A5;
    idle_chk("drop_idle", 1'b0);
    tick();
    dWEN = 2'b00;
    run_access(3, 1'b1, 1, 1'b1, 32'hF00, 32'h5A5A_A5A5, $urandom, "drop_d1w");

    // Reset while BUSY abandons the access; a late ram_rdy drops no wait bit.
    dREN = 2'b01;
    idle_chk("rmid_idle", 1'b0);
    tick();
    dREN = 2'b00;
    #1;
    chk("rmid busy ramREN", {63'd0, ramREN}, 64'd1);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    idle_chk("rmid_after", 1'b1);
    m_dptr = 1;
    m_iptr = 1;

    // Randomized traffic against the reference model; inputs scrambled while BUSY.
    for (int it = 0; it < 60; it++) begin
      iREN = 2'($urandom); dREN = 2'($urandom); dWEN = 2'($urandom);
      iaddr = {$urandom, $urandom}; daddr = {$urandom, $urandom}; dstore = {$urandom, $urandom};
      pick(found, is_d, cpu, wr);
      idle_chk($sformatf("rnd%0d idle", it), 1'($urandom_range(0, 1)));
      if (!found) begin
        tick();
        continue;
      end
      a = is_d ? daddr[cpu*32 +: 32] : iaddr[cpu*32 +: 32];
      s = dstore[cpu*32 +: 32];
      tick();
      iREN = 2'($urandom); dREN = 2'($urandom); dWEN = 2'($urandom);
      iaddr = {$urandom, $urandom}; daddr = {$urandom, $urandom}; dstore = {$urandom, $urandom};
      run_access($urandom_range(1, 4), is_d, cpu, wr, a, s, $urandom, $sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
